// File: rtl/pe_load_controller_if.sv
// Host-side stream and PE control bundle for pe_load_controller.
// master = controller, slave = host plus PE.
interface pe_load_controller_if;
    logic        START;
    logic [1:0]  DIMEN_IN;
    logic        IN_VALID;
    logic [31:0] IN_DATA;
    logic        IN_READY;
    logic        RES_VALID;
    logic [31:0] RES_DATA;
    logic        BUSY;
    logic        ERR;
    logic [31:0] DATAIN;
    logic        WRITE_MAT;
    logic        MAT_MUX;
    logic        RST_ADD;
    logic        RST_ACC;
    logic        RST_PC;
    logic        MAC_CTRL;
    logic [1:0]  DIMEN;
    logic        OUT_READY;
    logic        MAC_DONE;
    logic [31:0] DATAOUT;

    modport master (
        input  START, DIMEN_IN, IN_VALID, IN_DATA, MAC_DONE, DATAOUT,
        output IN_READY, RES_VALID, RES_DATA, BUSY, ERR, DATAIN,
        output WRITE_MAT, MAT_MUX, RST_ADD, RST_ACC, RST_PC,
        output MAC_CTRL, DIMEN, OUT_READY
    );

    modport slave (
        output START, DIMEN_IN, IN_VALID, IN_DATA, MAC_DONE, DATAOUT,
        input  IN_READY, RES_VALID, RES_DATA, BUSY, ERR, DATAIN,
        input  WRITE_MAT, MAT_MUX, RST_ADD, RST_ACC, RST_PC,
        input  MAC_CTRL, DIMEN, OUT_READY
    );
endinterface

// File: rtl/pe_load_controller.sv
// Sequencer feeding two operand vectors into a Processing_Element,
// running its MAC under a watchdog and returning the result.
module pe_load_controller #(
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    pe_load_controller_if.master bus
);
    localparam int CW = $clog2(N) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD_X, SWAP, LOAD_W, MAC, OUT, RESULT
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [1:0]  dimen_q, dimen_d;
    logic        err_q, err_d;
    logic [31:0] res_q, res_d;

    logic in_ready_q, in_ready_d;
    logic mat_mux_q, mat_mux_d;
    logic rst_add_q, rst_add_d;
    logic rst_clr_q, rst_clr_d;
    logic mac_ctrl_q, mac_ctrl_d;
    logic out_ready_q, out_ready_d;
    logic res_valid_q, res_valid_d;
    logic busy_q, busy_d;

    logic          accept;
    logic [CW-1:0] k_last;

    assign accept = bus.IN_VALID & in_ready_q;
    assign k_last = (CW'(2) << dimen_q) - CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        dimen_d = dimen_q;
        err_d   = err_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    dimen_d = bus.DIMEN_IN;
                    err_d   = 1'b0;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = LOAD_X;
            end
            LOAD_X: begin
                if (accept) begin
                    if (cnt_q == k_last) begin
                        cnt_d   = '0;
                        state_d = SWAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SWAP: state_d = LOAD_W;
            LOAD_W: begin
                if (accept) begin
                    if (cnt_q == k_last) begin
                        cnt_d   = '0;
                        wd_d    = '0;
                        state_d = MAC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            MAC: begin
                // completion takes priority over an expiring watchdog
                if (bus.MAC_DONE) begin
                    state_d = OUT;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            OUT: begin
                res_d   = bus.DATAOUT;
                state_d = RESULT;
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops mirror state_q.
    always_comb begin
        in_ready_d  = (state_d == LOAD_X) || (state_d == LOAD_W);
        mat_mux_d   = (state_d == LOAD_X);
        rst_add_d   = (state_d == CLR) || (state_d == SWAP);
        rst_clr_d   = (state_d == CLR);
        mac_ctrl_d  = (state_d == MAC);
        out_ready_d = (state_d == OUT);
        res_valid_d = (state_d == RESULT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            dimen_q     <= '0;
            err_q       <= 1'b0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            mat_mux_q   <= 1'b0;
            rst_add_q   <= 1'b0;
            rst_clr_q   <= 1'b0;
            mac_ctrl_q  <= 1'b0;
            out_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            dimen_q     <= dimen_d;
            err_q       <= err_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            mat_mux_q   <= mat_mux_d;
            rst_add_q   <= rst_add_d;
            rst_clr_q   <= rst_clr_d;
            mac_ctrl_q  <= mac_ctrl_d;
            out_ready_q <= out_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.WRITE_MAT = accept;
    assign bus.DATAIN    = accept ? bus.IN_DATA : 32'd0;
    assign bus.MAT_MUX   = mat_mux_q;
    assign bus.RST_ADD   = rst_add_q;
    assign bus.RST_ACC   = rst_clr_q;
    assign bus.RST_PC    = rst_clr_q;
    assign bus.MAC_CTRL  = mac_ctrl_q;
    assign bus.OUT_READY = out_ready_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_q;
    assign bus.BUSY      = busy_q;
    assign bus.ERR       = err_q;
    assign bus.DIMEN     = dimen_q;
endmodule
